// File: rtl/input_conditioner.sv
// Purpose: synchronize switches and debounce a pushbutton into a toggle, a clean level and press/release strobes.
// Latency: sw is 2 edges behind sw_raw; an accepted button change lands DEBOUNCE_CYCLES+2 edges after the first sample.
// Backpressure: none; the block free-runs every cycle and cannot stall.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic [3:0] sw_raw,
    output logic       pba,
    output logic [3:0] sw,
    output logic       btn_clean,
    output logic       press_pulse,
    output logic       release_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          btn_s1;
    logic          btn_s2;
    logic [3:0]    sw_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= 4'b0000;
            sw     <= 4'b0000;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= sw_raw;
            sw     <= sw_s1;
        end
    end

    // cnt is cleared on every state change and abort, so it never exceeds CNT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RELEASED;
            cnt           <= '0;
            pba           <= 1'b0;
            btn_clean     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (btn_s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s2) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        pba         <= ~pba;
                        press_pulse <= 1'b1;
                        btn_clean   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s2) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state         <= RELEASED;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        btn_clean     <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 (press/release lands 6 edges after first sample).
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic       pba;
    logic [3:0] sw;
    logic       btn_clean;
    logic       press_pulse;
    logic       release_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int press_cnt = 0;
    int release_cnt = 0;
    int both_cnt = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .sw_raw        (sw_raw),
        .pba           (pba),
        .sw            (sw),
        .btn_clean     (btn_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse) press_cnt++;
        if (release_pulse) release_cnt++;
        if (press_pulse && release_pulse) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pba"}, pba, 0);
        check({tag, ".btn_clean"}, btn_clean, 0);
        check({tag, ".press"}, press_pulse, 0);
        check({tag, ".release"}, release_pulse, 0);
        check({tag, ".sw"}, sw, 0);
    endtask

    // Assumes btn_raw was just raised; checks the press strobe lands only after the 7th edge (index 6).
    task automatic expect_press(input string tag, input logic exp_pba);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check({tag, ".press"}, press_pulse, (i == 6) ? 1 : 0);
            if (i == 5) check({tag, ".clean_before"}, btn_clean, 0);
        end
        check({tag, ".pba"}, pba, exp_pba);
        check({tag, ".clean"}, btn_clean, 1);
    endtask

    task automatic expect_release(input string tag, input logic exp_pba);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check({tag, ".release"}, release_pulse, (i == 6) ? 1 : 0);
            if (i == 5) check({tag, ".clean_before"}, btn_clean, 1);
        end
        check({tag, ".pba"}, pba, exp_pba);
        check({tag, ".clean"}, btn_clean, 0);
    endtask

    initial begin
        int p0, r0, bad;
        logic [3:0] prev;

        rst_n = 1'b0;
        btn_raw = 1'b0;
        sw_raw = 4'h0;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);
        check_all_zero("idle");

        btn_raw = 1'b1;
        expect_press("clean_press", 1'b1);
        btn_raw = 1'b0;
        expect_release("clean_release", 1'b1);

        // Bounce: high 3, low 1, then held high.
        p0 = press_cnt;
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(1);
        check("bounce.no_pulse", press_cnt - p0, 0);
        btn_raw = 1'b1;
        expect_press("bounce", 1'b0);
        check("bounce.one_pulse", press_cnt - p0, 1);
        btn_raw = 1'b0;
        expect_release("bounce_rel", 1'b0);

        p0 = press_cnt;
        r0 = release_cnt;
        for (int c = 0; c < 3; c++) begin
            btn_raw = 1'b1;
            tick(10);
            check("toggle.pba", pba, (c == 1) ? 0 : 1);
            btn_raw = 1'b0;
            tick(10);
        end
        check("toggle.presses", press_cnt - p0, 3);
        check("toggle.releases", release_cnt - r0, 3);

        prev = 4'h0;
        for (int v = 0; v < 16; v++) begin
            sw_raw = 4'(v);
            tick(1);
            check("sw.one_edge", sw, prev);
            tick(1);
            check("sw.two_edges", sw, v);
            tick(8);
            prev = 4'(v);
        end

        // pba is 1 and sw is F here, so an immediate clear is observable.
        btn_raw = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick(2);
        check_all_zero("rst_hold");
        sw_raw = 4'h0;
        rst_n = 1'b1;
        expect_press("post_reset", 1'b1);
        btn_raw = 1'b0;
        expect_release("post_reset_rel", 1'b1);

        p0 = press_cnt;
        bad = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (i >= 6 && btn_clean !== 1'b1) bad++;
        end
        check("hold.presses", press_cnt - p0, 1);
        check("hold.clean_drops", bad, 0);
        check("hold.pba", pba, 0);
        btn_raw = 1'b0;
        tick(10);

        check("never_both", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
